// File: rtl/adler32_accum_pkg.sv
// Shared types and constants for the Adler-32 accumulator and its modular adders.
package adler_pkg;

  localparam logic [15:0] ADLER_MOD_DEFAULT = 16'd65521;
  localparam int unsigned SUM_W             = 16;
  localparam int unsigned SLICE_W           = 4;
  localparam int unsigned N_SLICE           = SUM_W / SLICE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Both speculative results of one carry-select slice (carry-in 0 and 1)
  typedef struct packed {
    logic [SLICE_W:0] sum0;
    logic [SLICE_W:0] sum1;
  } slice_t;

  function automatic slice_t cs_slice(input logic [SLICE_W-1:0] a,
                                      input logic [SLICE_W-1:0] b);
    slice_t r;
    r.sum0 = {1'b0, a} + {1'b0, b};
    r.sum1 = {1'b0, a} + {1'b0, b} + (SLICE_W+1)'(1);
    return r;
  endfunction

endpackage

// File: rtl/adler32_accum_if.sv
// Byte-in / checksum-out handshake bundle for the Adler-32 accumulator.
interface adler32_accum_if;
  import adler_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*SUM_W-1:0]   out_adler;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_adler
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_adler
  );

endinterface

// File: rtl/adler32_accum_mod_add16.sv
// (a + b) mod MOD for a, b < MOD: carry-select 17-bit add, parallel modulus subtract, select.
module mod_add16
  import adler_pkg::*;
#(
  parameter logic [SUM_W-1:0] MOD = ADLER_MOD_DEFAULT
) (
  input  logic [SUM_W-1:0] i_a,
  input  logic [SUM_W-1:0] i_b,
  output logic [SUM_W-1:0] o_sum_c
);

  logic [SUM_W:0]   w_sum;
  logic [SUM_W-1:0] w_diff;
  logic             w_ge;
  logic             w_carry;
  slice_t           w_sl;

  // Ripple the select signal across 4-bit slices that precompute both carry cases
  always_comb begin
    w_sum   = '0;
    w_carry = 1'b0;
    w_sl    = '0;
    for (int unsigned i = 0; i < N_SLICE; i++) begin
      w_sl = cs_slice(i_a[i*SLICE_W +: SLICE_W], i_b[i*SLICE_W +: SLICE_W]);
      w_sum[i*SLICE_W +: SLICE_W] = w_carry ? w_sl.sum1[SLICE_W-1:0] : w_sl.sum0[SLICE_W-1:0];
      w_carry = w_carry ? w_sl.sum1[SLICE_W] : w_sl.sum0[SLICE_W];
    end
    w_sum[SUM_W] = w_carry;
  end

  // Difference fits in 16 bits whenever it is selected, so modular 16-bit subtract suffices
  assign w_diff  = w_sum[SUM_W-1:0] - MOD;
  assign w_ge    = (w_sum >= {1'b0, MOD});
  assign o_sum_c = w_ge ? w_diff : w_sum[SUM_W-1:0];

endmodule

// File: rtl/adler32_accum.sv
// Running Adler-32 over a byte stream; presents {s2, s1} once per frame.
module adler32_accum
  import adler_pkg::*;
#(
  parameter int unsigned ADLER_MOD = 32'(ADLER_MOD_DEFAULT),
  parameter int unsigned INIT_S1   = 1
) (
  input  logic             clk,
  input  logic             rst,
  adler32_accum_if.slave   bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [SUM_W-1:0]   r_s1;
  logic [SUM_W-1:0]   r_s2;
  logic [SUM_W-1:0]   w_s1n;
  logic [SUM_W-1:0]   w_s2n;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [2*SUM_W-1:0] r_out_adler;
  logic               w_accept;
  logic               w_release;

  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_release = r_out_valid & bus.out_ready;

  mod_add16 #(.MOD(SUM_W'(ADLER_MOD))) u_add_s1 (
    .i_a     (r_s1),
    .i_b     ({8'd0, bus.in_data}),
    .o_sum_c (w_s1n)
  );

  // s2 accumulates the freshly updated s1
  mod_add16 #(.MOD(SUM_W'(ADLER_MOD))) u_add_s2 (
    .i_a     (r_s2),
    .i_b     (w_s1n),
    .o_sum_c (w_s2n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, ACCUM: if (w_accept)  w_state_nxt = bus.in_last ? DONE : ACCUM;
      DONE:        if (w_release) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so neither depends on the peer's signal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1        <= SUM_W'(INIT_S1);
      r_s2        <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_adler <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt != DONE);
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_s1 <= w_s1n;
        r_s2 <= w_s2n;
        if (bus.in_last) r_out_adler <= {w_s2n, w_s1n};
      end else if (w_release) begin
        r_s1 <= SUM_W'(INIT_S1);
        r_s2 <= '0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_adler = r_out_adler;

endmodule

// File: tb/tb_adler32_accum.sv
// Directed bench for adler32_accum with an expected-checksum queue and a software Adler-32 model.
module tb_adler32_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adler32_accum_if bus ();

  adler32_accum dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0]  exp_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  byte unsigned frame[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] adler_ref(input byte unsigned d[$]);
    int unsigned a = 1;
    int unsigned b = 0;
    foreach (d[i]) begin
      a = (a + 32'(d[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  function automatic void load_str(input string s);
    frame.delete();
    for (int i = 0; i < s.len(); i++) frame.push_back(byte'(s[i]));
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send_byte(input logic [7:0] b, input logic last);
    int waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.in_ready !== 1'b1) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct, input bit chk_ready,
                            input bit use_const, input logic [31:0] const_exp);
    exp_q.push_back(use_const ? const_exp : adler_ref(frame));
    foreach (frame[i]) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) begin
          bus.in_data = 8'($urandom);
          bus.in_last = 1'($urandom);
          @(negedge clk);
        end
      end
      if (chk_ready) check("in_ready_stream", 32'(bus.in_ready), 32'd1);
      send_byte(frame[i], 1'(i == frame.size() - 1));
    end
  endtask

  task automatic recv(input string tag);
    int          waitc = 0;
    logic [31:0] e;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.out_adler, e);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_adler", bus.out_adler, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, latency 1
    load_str("a");
    send_frame(0, 1'b1, 1'b1, 32'h0062_0062);
    check("a_latency", 32'(bus.out_valid), 32'd1);
    recv("a");
    @(negedge clk);

    load_str("abc");
    send_frame(0, 1'b1, 1'b1, 32'h024D_0127);
    recv("abc");
    @(negedge clk);

    load_str("Wikipedia");
    send_frame(0, 1'b1, 1'b1, 32'h11E6_0398);
    recv("wikipedia");
    @(negedge clk);

    frame.delete();
    repeat (257) frame.push_back(8'hFF);
    send_frame(0, 1'b0, 1'b1, 32'h080F_000F);
    recv("ff_257");
    @(negedge clk);

    frame.delete();
    repeat (1024) frame.push_back(8'h00);
    send_frame(0, 1'b0, 1'b1, 32'h0400_0001);
    recv("zero_1024");
    @(negedge clk);

    // Backpressure: checksum held, offered bytes not consumed
    load_str("a");
    send_frame(0, 1'b0, 1'b1, 32'h0062_0062);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_last  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_adler", bus.out_adler, 32'h0062_0062);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    recv("bp_a");
    load_str("abc");
    send_frame(0, 1'b0, 1'b1, 32'h024D_0127);
    recv("bp_abc");
    @(negedge clk);

    // Random frame with unqualified garbage during gaps
    frame.delete();
    repeat (5000) frame.push_back(8'($urandom));
    send_frame(30, 1'b0, 1'b0, 32'd0);
    recv("rand_5000");
    @(negedge clk);

    // Reset mid-frame: partial frame must not produce a checksum
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_str("a");
    send_frame(0, 1'b0, 1'b1, 32'h0062_0062);
    recv("after_rst_a");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_extra_out", 32'(bus.out_valid), 32'd0);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adler32_accum.md
Name: adler32_accum

Overview:
- Running Adler-32 checksum engine for the zlib wrapper of the Deflate output stream.
- Consumes the compressor's byte stream one byte per cycle over a valid/ready handshake.
- Maintains the two modular sums. These are built from chains of the team's 4-bit carry-select adder slices.
- Emits the 32-bit checksum, {s2, s1}, once per frame for the trailer formatter downstream.

Parameters:
- ADLER_MOD, 65521, modulus for both sums; must be less than 2^16.
- INIT_S1, 1, value loaded into s1 at reset and at the start of each frame.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  8  payload byte.
- in_last  in  1  marks the final byte of the frame; qualified by in_valid.
- out_valid  out  1  checksum valid.
- out_ready  in  1  downstream accepts the checksum.
- out_adler  out  32  {s2[15:0], s1[15:0]}.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: s1 = INIT_S1, s2 = 0, state = IDLE, in_ready = 0 during reset, out_valid = 0, out_adler = 0.
- States:
  - IDLE: no frame open. in_ready = 1.
  - ACCUM: frame open. in_ready = 1.
  - DONE: checksum presented. in_ready = 0, out_valid = 1.
- Accept condition: a beat is accepted when in_valid & in_ready.
  - s1n = s1 + in_data; if s1n >= ADLER_MOD, subtract ADLER_MOD. The result is always < ADLER_MOD because s1 + 255 < 2*ADLER_MOD.
  - s2n = s2 + s1n (17-bit); if >= ADLER_MOD, subtract once.
  - Both sums register in the same cycle as acceptance. Throughput is 1 byte/cycle with no bubbles.
- Transitions:
  - IDLE -> ACCUM: accepted beat with in_last = 0.
  - IDLE or ACCUM -> DONE: accepted beat with in_last = 1. out_adler = {s2n, s1n} is registered in that cycle, so out_valid rises the next cycle (latency 1 from the last byte).
  - ACCUM stays in ACCUM on non-last beats.
  - DONE -> IDLE: when out_valid & out_ready. s1 is reloaded to INIT_S1 and s2 to 0 in the same edge; out_valid drops.
- Output stability: out_adler and out_valid hold stable while out_ready = 0. No new bytes are accepted in DONE.
- Empty frames: not supported; every frame carries at least one byte.
- Unqualified inputs: in_data and in_last are ignored when in_valid = 0.
- Reset mid-frame: partial sums are discarded, state returns to IDLE, and no checksum is emitted for the aborted frame.
- Handshake independence: in_ready does not depend combinationally on in_valid. out_valid does not depend combinationally on out_ready.

Decomposition:
- Shared package adler_pkg:
  - ADLER_MOD_DEFAULT = 16'd65521.
  - State enum {IDLE, ACCUM, DONE}.
  - Width constant SUM_W = 16.
- Sub-module mod_add16:
  - 17-bit carry-select sum from cascaded 4-bit carry-select slices.
  - Parallel subtract of the modulus.
  - Selects the reduced result on compare.
  - Instantiated twice (s1 path, s2 path), fully combinational.

Test Plan:
- Single byte "a" (0x61) with in_last -> out_adler = 0x00620062, out_valid one cycle after acceptance.
- "abc" streamed back-to-back -> 0x024D0127; "Wikipedia" (9 bytes) -> 0x11E60398; in_ready stays 1 throughout.
- 257 bytes of 0xFF -> s1 wraps and s2 reduces, out_adler = 0x080F000F; 1024 bytes of 0x00 -> 0x04000001.
- Backpressure: hold out_ready = 0 for 10 cycles after "a" -> out_adler stays 0x00620062, in_ready = 0, in_valid bytes are not consumed. Release, then the next frame "abc" -> 0x024D0127 (sums reinitialised).
- Random in_valid gaps on a 5000-byte random frame -> matches the software Adler-32 model; gaps do not alter the sums.
- Assert rst mid-frame after 3 bytes, then send "a" -> only 0x00620062 is emitted; no checksum for the aborted frame.
